// File: rtl/seg7_pkg.sv
// Shared constants and types for the scanned 7-segment capture block.
// Segment patterns are {a,b,c,d,e,f,g}, active-high.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h7E;
    localparam logic [6:0] SEG_1 = 7'h30;
    localparam logic [6:0] SEG_2 = 7'h6D;
    localparam logic [6:0] SEG_3 = 7'h79;
    localparam logic [6:0] SEG_4 = 7'h33;
    localparam logic [6:0] SEG_5 = 7'h5B;
    localparam logic [6:0] SEG_6 = 7'h5F;
    localparam logic [6:0] SEG_7 = 7'h70;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h7B;

    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

endpackage

// File: rtl/seg2bcd.sv
// Combinational 7-segment pattern to BCD lookup.
// Ports: seg (pattern in), bcd (digit or 4'hF), inv (pattern not a digit).
module seg2bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] bcd,
    output logic       inv
);

    always_comb begin
        bcd = BCD_INVALID;
        inv = 1'b0;
        unique case (1'b1)
            (seg == SEG_0): bcd = 4'd0;
            (seg == SEG_1): bcd = 4'd1;
            (seg == SEG_2): bcd = 4'd2;
            (seg == SEG_3): bcd = 4'd3;
            (seg == SEG_4): bcd = 4'd4;
            (seg == SEG_5): bcd = 4'd5;
            (seg == SEG_6): bcd = 4'd6;
            (seg == SEG_7): bcd = 4'd7;
            (seg == SEG_8): bcd = 4'd8;
            (seg == SEG_9): bcd = 4'd9;
            default: begin
                bcd = BCD_INVALID;
                inv = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decodificador_7seg.sv
// Captures a scanned multi-digit 7-segment display into a BCD word.
// Ports: clk, rst_n, seg_i, dig_en_i in; bcd_o, valid_o, err_o, digit_err_o out.
module decodificador_7seg
    import seg7_pkg::*;
#(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          seg_i,
    input  logic [NDIG-1:0]     dig_en_i,
    output logic [4*NDIG-1:0]   bcd_o,
    output logic                valid_o,
    output logic                err_o,
    output logic [NDIG-1:0]     digit_err_o
);

    localparam logic [3:0] ST = 4'(STABLE);

    logic [6:0]        smp_seg;
    logic [NDIG-1:0]   smp_dig;
    logic [6:0]        prv_seg;
    logic [NDIG-1:0]   prv_dig;
    state_t            state;
    state_t            nxt_state;
    logic [3:0]        cnt;
    logic [3:0]        nxt_cnt;
    logic [NDIG-1:0]   seen;
    logic [4*NDIG-1:0] sh_bcd;
    logic [NDIG-1:0]   sh_err;
    logic [4*NDIG-1:0] mrg_bcd;
    logic [NDIG-1:0]   mrg_err;
    logic [3:0]        dec_bcd;
    logic              dec_inv;
    logic              vld;
    logic              same;
    logic              cap;
    logic              full;

    seg2bcd u_dec (
        .seg (smp_seg),
        .bcd (dec_bcd),
        .inv (dec_inv)
    );

    // Only a one-hot strobe identifies a digit; anything else is a gap.
    assign vld  = (smp_dig != '0) &&
                  ((smp_dig & (smp_dig - 1'b1)) == '0);
    assign same = (smp_seg == prv_seg) && (smp_dig == prv_dig);
    assign full = &(seen | smp_dig);

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        cap       = 1'b0;
        if (!vld) begin
            nxt_state = IDLE;
            nxt_cnt   = 4'd0;
        end else if (state == TRACK && same) begin
            if (cnt < ST)
                nxt_cnt = cnt + 4'd1;
        end else if (state == HOLD && same) begin
            nxt_state = HOLD;
        end else begin
            nxt_state = TRACK;
            nxt_cnt   = 4'd1;
        end
        // Dwell long enough: capture once, then park in HOLD.
        if (vld && nxt_state == TRACK && nxt_cnt == ST) begin
            cap       = 1'b1;
            nxt_state = HOLD;
        end
    end

    // Shadow with the digit being captured merged in.
    always_comb begin
        mrg_bcd = sh_bcd;
        mrg_err = sh_err;
        for (int i = 0; i < NDIG; i++) begin
            if (smp_dig[i]) begin
                mrg_bcd[4*i +: 4] = dec_bcd;
                mrg_err[i]        = dec_inv;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_seg     <= '0;
            smp_dig     <= '0;
            prv_seg     <= '0;
            prv_dig     <= '0;
            state       <= IDLE;
            cnt         <= '0;
            seen        <= '0;
            sh_bcd      <= '0;
            sh_err      <= '0;
            bcd_o       <= '0;
            digit_err_o <= '0;
            err_o       <= 1'b0;
            valid_o     <= 1'b0;
        end else begin
            smp_seg <= seg_i;
            smp_dig <= dig_en_i;
            prv_seg <= smp_seg;
            prv_dig <= smp_dig;
            state   <= nxt_state;
            cnt     <= nxt_cnt;
            valid_o <= 1'b0;
            if (cap) begin
                if (full) begin
                    bcd_o       <= mrg_bcd;
                    digit_err_o <= mrg_err;
                    err_o       <= |mrg_err;
                    valid_o     <= 1'b1;
                    seen        <= '0;
                end else begin
                    sh_bcd <= mrg_bcd;
                    sh_err <= mrg_err;
                    seen   <= seen | smp_dig;
                end
            end
        end
    end

endmodule

// File: tb/tb_decodificador_7seg.sv
// Directed bench for decodificador_7seg (NDIG=4, STABLE=3).
// Frames are driven as dwells and checked against hand-computed words.
module tb_decodificador_7seg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg_i = '0;
    logic [3:0]  dig_en_i = '0;
    logic [15:0] bcd_o;
    logic        valid_o;
    logic        err_o;
    logic [3:0]  digit_err_o;

    decodificador_7seg #(.NDIG(4), .STABLE(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_i       (seg_i),
        .dig_en_i    (dig_en_i),
        .bcd_o       (bcd_o),
        .valid_o     (valid_o),
        .err_o       (err_o),
        .digit_err_o (digit_err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int vcount = 0;
    int vcyc   = 0;
    int t_last = 0;
    int b2b    = 0;
    logic        pv = 1'b0;
    logic [15:0] cap_bcd = '0;
    logic        cap_err = 1'b0;
    logic [3:0]  cap_derr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o) begin
            vcount   = vcount + 1;
            vcyc     = cyc;
            cap_bcd  = bcd_o;
            cap_err  = err_o;
            cap_derr = digit_err_o;
            if (pv) b2b = b2b + 1;
        end
        pv = valid_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [6:0] s, input logic [3:0] d,
                         input int n);
        seg_i    = s;
        dig_en_i = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                         input logic [6:0] s2, input logic [6:0] s3);
        logic [6:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int d = 0; d < 4; d++) begin
            if (d == 3) t_last = cyc + 1;
            drive(s[d], 4'(1 << d), 5);
            drive(7'h00, 4'b0000, 1);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int v0;
        // Reset and idle
        repeat (3) @(negedge clk);
        chk("rst_bcd", bcd_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_derr", digit_err_o, 0);
        rst_n = 1'b1;
        drive(7'h00, 4'b0000, 20);
        chk("idle_vcount", vcount, 0);
        chk("idle_bcd", bcd_o, 0);

        // Clean frame 3,4,5,0
        frame(7'h79, 7'h33, 7'h5B, 7'h7E);
        chk("clean_vcount", vcount, 1);
        chk("clean_bcd", cap_bcd, 16'h0543);
        chk("clean_err", cap_err, 0);
        chk("clean_derr", cap_derr, 0);
        chk("clean_lat", vcyc - t_last, 3);
        chk("clean_hold", bcd_o, 16'h0543);

        // Invalid pattern on digit 2
        frame(7'h79, 7'h33, 7'h01, 7'h7E);
        chk("inv_vcount", vcount, 2);
        chk("inv_bcd", cap_bcd, 16'h0F43);
        chk("inv_derr", cap_derr, 4'b0100);
        chk("inv_err", cap_err, 1);

        // Glitch on digit 1: short 1, then stable 2
        drive(7'h79, 4'b0001, 5);
        drive(7'h00, 4'b0000, 1);
        drive(7'h30, 4'b0010, 2);
        drive(7'h6D, 4'b0010, 4);
        drive(7'h00, 4'b0000, 1);
        drive(7'h5B, 4'b0100, 5);
        drive(7'h00, 4'b0000, 1);
        drive(7'h7E, 4'b1000, 5);
        drive(7'h00, 4'b0000, 3);
        chk("glitch_vcount", vcount, 3);
        chk("glitch_bcd", cap_bcd, 16'h0523);
        chk("glitch_err", cap_err, 0);

        // Multi-hot strobe is a gap
        drive(7'h7F, 4'b0011, 10);
        chk("multi_vcount", vcount, 3);
        chk("multi_hold", bcd_o, 16'h0523);
        frame(7'h30, 7'h30, 7'h30, 7'h30);
        chk("multi_frame_vc", vcount, 4);
        chk("multi_frame_bcd", cap_bcd, 16'h1111);
        chk("multi_frame_err", cap_err, 0);

        // Overwrite of a slot with a long dwell
        drive(7'h30, 4'b0001, 5);
        drive(7'h00, 4'b0000, 1);
        drive(7'h6D, 4'b0001, 20);
        drive(7'h00, 4'b0000, 1);
        chk("ovw_nopub", vcount, 4);
        drive(7'h79, 4'b0010, 5);
        drive(7'h00, 4'b0000, 1);
        drive(7'h33, 4'b0100, 5);
        drive(7'h00, 4'b0000, 1);
        drive(7'h5B, 4'b1000, 5);
        drive(7'h00, 4'b0000, 3);
        chk("ovw_vcount", vcount, 5);
        chk("ovw_bcd", cap_bcd, 16'h5432);

        // Reset mid-frame discards partial capture
        drive(7'h30, 4'b0001, 5);
        drive(7'h30, 4'b0010, 5);
        drive(7'h30, 4'b0100, 5);
        drive(7'h00, 4'b0000, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bcd", bcd_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = vcount;
        drive(7'h70, 4'b1000, 5);
        drive(7'h00, 4'b0000, 5);
        chk("mid_no_pub", vcount, v0);
        drive(7'h7F, 4'b0001, 5);
        drive(7'h7B, 4'b0010, 5);
        chk("mid_no_pub2", vcount, v0);
        drive(7'h5F, 4'b0100, 5);
        drive(7'h00, 4'b0000, 2);
        chk("mid_vcount", vcount, v0 + 1);
        chk("mid_bcd", cap_bcd, 16'h7698);

        chk("no_b2b", b2b, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
